// File: rtl/fxp_mul_pipe_pkg.sv
// Shared fixed-point definitions: rounding modes and Q-format width helpers,
// also used by the downstream accumulator.
package fxp_mul_pipe_pkg;

  typedef enum logic {
    TRUNC = 1'b0,
    RNE   = 1'b1
  } rnd_mode_e;

  function automatic int unsigned prod_wl(input int unsigned wl_a, input int unsigned wl_b);
    return wl_a + wl_b;
  endfunction

  function automatic int unsigned prod_scale(input int unsigned scale_a,
                                             input int unsigned scale_b);
    return scale_a + scale_b;
  endfunction

  // Number of fraction LSBs dropped when narrowing scale_in to scale_out.
  function automatic int unsigned drop_count(input int unsigned scale_in,
                                             input int unsigned scale_out);
    return (scale_in > scale_out) ? scale_in - scale_out : 0;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational Q-format conversion: guard/sticky round-to-nearest-even (or
// truncation) when narrowing, left shift when widening, then unsigned saturation.
module fxp_round_sat
  import fxp_mul_pipe_pkg::*;
#(
  parameter int unsigned wl_in     = 32,
  parameter int unsigned scale_in  = 16,
  parameter int unsigned wl_out    = 32,
  parameter int unsigned scale_out = 5,
  parameter rnd_mode_e   mode      = RNE
) (
  input  logic [wl_in-1:0]  data_in,
  output logic [wl_out-1:0] data_out,
  output logic              ovf
);

  localparam int unsigned Drop  = drop_count(scale_in, scale_out);
  localparam int unsigned Shift = (scale_out > scale_in) ? scale_out - scale_in : 0;
  // Wide enough to hold any shifted or rounded value plus the bits above wl_out.
  localparam int unsigned Ww    = wl_in + Shift + wl_out + 1;

  logic [Ww-1:0] scaled;

  if (Drop > 0) begin : g_round
    localparam logic [wl_in-1:0] StickyMask = {wl_in{1'b1}} >> (wl_in - Drop + 1);
    logic [wl_in-1:0] kept;
    logic             guard;
    logic             sticky;
    logic             round_up;

    assign kept     = data_in >> Drop;
    assign guard    = data_in[Drop-1];
    assign sticky   = |(data_in & StickyMask);
    assign round_up = (mode == RNE) && guard && (sticky || kept[0]);
    // A rounding carry can push the value past wl_out; caught by ovf below.
    assign scaled   = Ww'(kept) + Ww'(round_up);
  end else begin : g_shift
    assign scaled = Ww'(data_in) << Shift;
  end

  assign ovf      = |(scaled >> wl_out);
  assign data_out = ovf ? {wl_out{1'b1}} : scaled[wl_out-1:0];

endmodule

// File: rtl/fxp_mul_pipe.sv
// Three-stage unsigned fixed-point multiplier (operands, full product, converted
// result) with valid/ready on both sides; out_data/out_ovf read 0 when not valid.
module fxp_mul_pipe
  import fxp_mul_pipe_pkg::*;
#(
  parameter int unsigned wl_a      = 16,
  parameter int unsigned scale_a   = 8,
  parameter int unsigned wl_b      = 16,
  parameter int unsigned scale_b   = 8,
  parameter int unsigned wl_out    = 32,
  parameter int unsigned scale_out = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [wl_a-1:0]   in_a,
  input  logic [wl_b-1:0]   in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [wl_out-1:0] out_data,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned Pw = prod_wl(wl_a, wl_b);
  localparam int unsigned Ps = prod_scale(scale_a, scale_b);

  logic              v1_q, v2_q, v3_q;
  logic [wl_a-1:0]   a1_q;
  logic [wl_b-1:0]   b1_q;
  logic [Pw-1:0]     p2_q;
  logic [wl_out-1:0] d3_q;
  logic              o3_q;
  logic              load1, load2, load3;
  logic [wl_out-1:0] rs_data;
  logic              rs_ovf;

  // A stage loads when empty or when its contents move on this cycle.
  assign load3    = !v3_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  fxp_round_sat #(
    .wl_in    (Pw),
    .scale_in (Ps),
    .wl_out   (wl_out),
    .scale_out(scale_out),
    .mode     (RNE)
  ) u_round_sat (
    .data_in (p2_q),
    .data_out(rs_data),
    .ovf     (rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      p2_q <= '0;
      d3_q <= '0;
      o3_q <= 1'b0;
    end else begin
      if (load1) begin
        v1_q <= in_valid;
        a1_q <= in_a;
        b1_q <= in_b;
      end
      if (load2) begin
        v2_q <= v1_q;
        p2_q <= Pw'(a1_q) * Pw'(b1_q);
      end
      // Bubbles load zeros so the idle output adds nothing downstream.
      if (load3) begin
        v3_q <= v2_q;
        d3_q <= v2_q ? rs_data : '0;
        o3_q <= v2_q && rs_ovf;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = d3_q;
  assign out_ovf   = o3_q;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Scoreboard bench: default-format instance (Q.5 out) and a 16-bit Q8.8-out
// instance for saturation; monitors compare every presented output to the queue.
module tb_fxp_mul_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_valid_d = 1'b0;
  logic        in_valid_s = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready_d, in_ready_s;
  logic [31:0] out_data_d;
  logic [15:0] out_data_s;
  logic        out_ovf_d, out_ovf_s;
  logic        out_valid_d, out_valid_s;

  exp_t q_d[$];
  exp_t q_s[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  fxp_mul_pipe dut_d (
    .clk      (clk),
    .rst      (rst),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid_d),
    .in_ready (in_ready_d),
    .out_data (out_data_d),
    .out_ovf  (out_ovf_d),
    .out_valid(out_valid_d),
    .out_ready(out_ready)
  );

  fxp_mul_pipe #(
    .wl_out   (16),
    .scale_out(8)
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid_s),
    .in_ready (in_ready_s),
    .out_data (out_data_s),
    .out_ovf  (out_ovf_s),
    .out_valid(out_valid_s),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Present one pair to the selected instance, hold until accepted, log expectation.
  task automatic send(input bit sel, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp_data, input logic exp_ovf);
    int   cnt;
    exp_t e;
    @(negedge clk);
    in_a = a;
    in_b = b;
    if (sel) in_valid_s = 1'b1;
    else in_valid_d = 1'b1;
    #1;
    cnt = 0;
    while (!(sel ? in_ready_s : in_ready_d) && cnt < 50) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 50) begin
      timeout("send_accept");
      in_valid_d = 1'b0;
      in_valid_s = 1'b0;
      return;
    end
    e.data = exp_data;
    e.ovf  = exp_ovf;
    if (sel) q_s.push_back(e);
    else q_d.push_back(e);
    @(posedge clk);
    #1;
    in_valid_d = 1'b0;
    in_valid_s = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while ((q_d.size() != 0 || q_s.size() != 0) && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 60) timeout("drain");
  endtask

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (out_valid_d) begin
        if (q_d.size() == 0) begin
          chk("unexpected_out_d", out_data_d, 32'hdead_beef);
        end else begin
          chk("data_d", out_data_d, q_d[0].data);
          chk("ovf_d", 32'(out_ovf_d), 32'(q_d[0].ovf));
          if (out_ready && rst) void'(q_d.pop_front());
        end
      end else begin
        chk("idle_data_d", out_data_d, 32'h0);
        chk("idle_ovf_d", 32'(out_ovf_d), 32'h0);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (out_valid_s) begin
        if (q_s.size() == 0) begin
          chk("unexpected_out_s", 32'(out_data_s), 32'hdead_beef);
        end else begin
          chk("data_s", 32'(out_data_s), q_s[0].data);
          chk("ovf_s", 32'(out_ovf_s), 32'(q_s[0].ovf));
          if (out_ready && rst) void'(q_s.pop_front());
        end
      end else begin
        chk("idle_data_s", 32'(out_data_s), 32'h0);
        chk("idle_ovf_s", 32'(out_ovf_s), 32'h0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid_d), 32'h0);
    chk("rst_data", out_data_d, 32'h0);
    chk("rst_ovf", 32'(out_ovf_d), 32'h0);
    chk("rst_in_ready", 32'(in_ready_d), 32'h1);
    rst = 1'b1;
    mon_en = 1'b1;

    // 1.5 * 2.0 = 3.0 -> 3*32 = 0x60; result registered two edges after the accept edge.
    send(1'b0, 16'h0180, 16'h0200, 32'h60, 1'b0);
    chk("lat_accept", 32'(out_valid_d), 32'h0);
    @(posedge clk); #1;
    chk("lat_s2", 32'(out_valid_d), 32'h0);
    @(posedge clk); #1;
    chk("lat_s3", 32'(out_valid_d), 32'h1);
    drain();

    // Default format drops 11 LSBs: guard is bit 10, sticky is bits 9..0.
    send(1'b0, 16'h0001, 16'h0400, 32'h0, 1'b0);  // tie, even kept
    send(1'b0, 16'h0003, 16'h0400, 32'h2, 1'b0);  // tie, odd kept
    send(1'b0, 16'h0001, 16'h0401, 32'h1, 1'b0);  // sticky set
    drain();

    // 16-bit Q8.8 output drops 8 LSBs.
    send(1'b1, 16'h1000, 16'h1000, 32'hffff, 1'b1);  // 16*16 overflows
    send(1'b1, 16'h0fff, 16'h1001, 32'hffff, 1'b1);  // 0xFFFFFF: round carry saturates
    send(1'b1, 16'hffff, 16'h0100, 32'hffff, 1'b0);  // 255.996 exact, fits, no ovf
    send(1'b1, 16'h0180, 16'h0200, 32'h0300, 1'b0);
    send(1'b1, 16'h0180, 16'h0001, 32'h0002, 1'b0);  // 0x180: tie, odd kept
    drain();

    // b = 2^11 makes the default-format result equal a exactly.
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(1'b0, 16'(16'h0010 + k), 16'h0800, 32'(16'h0010 + k), 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("stall_in_ready", 32'(in_ready_d), 32'h0);
          @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready_d), 32'h1);
      end
    join
    drain();

    // Reset with three pairs in flight; all must be discarded.
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, 16'h0020, 16'h0800, 32'h20, 1'b0);
    send(1'b0, 16'h0021, 16'h0800, 32'h21, 1'b0);
    send(1'b0, 16'h0022, 16'h0800, 32'h22, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q_d.delete();
    #1;
    chk("post_rst_valid", 32'(out_valid_d), 32'h0);
    chk("post_rst_data", out_data_d, 32'h0);
    chk("post_rst_ovf", 32'(out_ovf_d), 32'h0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    send(1'b0, 16'h0180, 16'h0200, 32'h60, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    chk("queue_d_empty", 32'(q_d.size()), 32'h0);
    chk("queue_s_empty", 32'(q_s.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
